// File: rtl/dice_game_pkg.sv
// ---------------------------------------------------------------------------
// dice_game_pkg
// Shared types and constants for the two-player dice game round sequencer.
//   state_t   : sequencer states (IDLE, WAIT1, WAIT2, SHOW, FINAL)
//   SCORE_W   : score width, DIE_W : die face width
//   DIE_MIN/DIE_MAX : legal face range, SCORE_MAX : score saturation value
//   die_valid : true when a face is a legal die value
//   sat_inc   : score increment that sticks at SCORE_MAX
// ---------------------------------------------------------------------------
package dice_game_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WAIT1,
    WAIT2,
    SHOW,
    FINAL
  } state_t;

  localparam int SCORE_W = 4;
  localparam int DIE_W   = 3;

  localparam logic [DIE_W-1:0]   DIE_MIN   = 3'd1;
  localparam logic [DIE_W-1:0]   DIE_MAX   = 3'd6;
  localparam logic [SCORE_W-1:0] SCORE_MAX = 4'd15;

  function automatic logic die_valid(input logic [DIE_W-1:0] v);
    return (v >= DIE_MIN) && (v <= DIE_MAX);
  endfunction

  function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] s);
    return (s == SCORE_MAX) ? s : s + SCORE_W'(1);
  endfunction

endpackage

// File: rtl/dice_game_ctrl_if.sv
// ---------------------------------------------------------------------------
// dice_game_ctrl_if
// Bundles the button/dice inputs and the display-facing outputs of the
// round sequencer.
//   roll, dice_value              : from button/debounce and dice generator
//   times, is_final, is_finish    : display mode controls
//   score1, score2                : player scores
//   die1, die2                    : last latched faces (0 = none)
//   cur_player, round_no          : whose turn, rounds completed
// Modports: master drives roll/dice_value, slave (the sequencer) drives
// everything else.
// ---------------------------------------------------------------------------
interface dice_game_ctrl_if;
  import dice_game_pkg::*;

  logic               roll;
  logic [DIE_W-1:0]   dice_value;
  logic               times;
  logic               is_final;
  logic               is_finish;
  logic [SCORE_W-1:0] score1;
  logic [SCORE_W-1:0] score2;
  logic [DIE_W-1:0]   die1;
  logic [DIE_W-1:0]   die2;
  logic               cur_player;
  logic [3:0]         round_no;

  modport master (
    output roll, dice_value,
    input  times, is_final, is_finish, score1, score2,
           die1, die2, cur_player, round_no
  );

  modport slave (
    input  roll, dice_value,
    output times, is_final, is_finish, score1, score2,
           die1, die2, cur_player, round_no
  );

endinterface

// File: rtl/dice_game_ctrl_rise_pulse.sv
// ---------------------------------------------------------------------------
// rise_pulse
// Rising-edge detector: one register plus an AND gate.
//   clk, rst : clock and synchronous active-high reset
//   rst_val  : value loaded into the delay register on reset; loading 1
//              keeps a level held through reset from firing afterwards
//   din      : level input
//   pulse    : high for the cycle in which din is 1 and was 0 last cycle
// ---------------------------------------------------------------------------
module rise_pulse (
  input  logic clk,
  input  logic rst,
  input  logic rst_val,
  input  logic din,
  output logic pulse
);

  logic din_d;

  always_ff @(posedge clk) begin
    if (rst) din_d <= rst_val;
    else     din_d <= din;
  end

  assign pulse = din & ~din_d;

endmodule

// File: rtl/dice_game_ctrl.sv
// ---------------------------------------------------------------------------
// dice_game_ctrl
// Round sequencer for the two-player dice game. Player 1 then player 2 roll,
// the higher face scores a point, the result is shown for SHOW_CYCLES, and
// the game ends once regulation rounds are done and the scores differ, or
// when MAX_ROUNDS is reached.
// Parameters:
//   ROUNDS      : regulation rounds per game (1..14)
//   MAX_ROUNDS  : hard round cap including sudden death (ROUNDS..15)
//   SHOW_CYCLES : cycles the round result is held
// Ports:
//   clk, rst : clock and synchronous active-high reset
//   bus      : dice_game_ctrl_if slave modport (roll/dice_value in,
//              display and status outputs out, all registered)
// ---------------------------------------------------------------------------
module dice_game_ctrl
  import dice_game_pkg::*;
#(
  parameter int ROUNDS      = 3,
  parameter int MAX_ROUNDS  = 15,
  parameter int SHOW_CYCLES = 50_000_000
) (
  input logic             clk,
  input logic             rst,
  dice_game_ctrl_if.slave bus
);

  localparam int TMR_W = (SHOW_CYCLES > 1) ? $clog2(SHOW_CYCLES) : 1;
  localparam logic [TMR_W-1:0] SHOW_LOAD = TMR_W'(SHOW_CYCLES - 1);
  localparam logic [3:0] ROUNDS_L = 4'(ROUNDS);
  localparam logic [3:0] MAX_L    = 4'(MAX_ROUNDS);

  state_t             state;
  logic [TMR_W-1:0]   timer;
  logic               roll_p;
  logic               times_q;
  logic               is_final_q;
  logic               is_finish_q;
  logic [SCORE_W-1:0] score1_q;
  logic [SCORE_W-1:0] score2_q;
  logic [DIE_W-1:0]   die1_q;
  logic [DIE_W-1:0]   die2_q;
  logic               cur_player_q;
  logic [3:0]         round_q;
  logic [3:0]         round_next;
  logic               face_ok;
  logic               game_over;

  // Delay register resets to 1 so a button held through reset needs a
  // release and a fresh press before it counts.
  rise_pulse u_rise (
    .clk    (clk),
    .rst    (rst),
    .rst_val(1'b1),
    .din    (bus.roll),
    .pulse  (roll_p)
  );

  assign face_ok    = die_valid(bus.dice_value);
  assign round_next = round_q + 4'd1;
  // A tie at the round cap still ends the game; the display treats it as a
  // player 2 win, so no score adjustment is needed here.
  assign game_over  = ((round_next >= ROUNDS_L) && (score1_q != score2_q)) ||
                      (round_next == MAX_L);

  // Sequencer with registered outputs; every output is updated on the same
  // edge as the state change so the display never sees a mixed picture.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      timer        <= '0;
      times_q      <= 1'b0;
      is_final_q   <= 1'b0;
      is_finish_q  <= 1'b0;
      score1_q     <= '0;
      score2_q     <= '0;
      die1_q       <= '0;
      die2_q       <= '0;
      cur_player_q <= 1'b0;
      round_q      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (roll_p) begin
            state        <= WAIT1;
            times_q      <= 1'b1;
            cur_player_q <= 1'b0;
          end
        end
        WAIT1: begin
          if (roll_p && face_ok) begin
            die1_q       <= bus.dice_value;
            state        <= WAIT2;
            cur_player_q <= 1'b1;
          end
        end
        WAIT2: begin
          if (roll_p && face_ok) begin
            die2_q <= bus.dice_value;
            if (die1_q > bus.dice_value)      score1_q <= sat_inc(score1_q);
            else if (die1_q < bus.dice_value) score2_q <= sat_inc(score2_q);
            timer        <= SHOW_LOAD;
            state        <= SHOW;
            times_q      <= 1'b0;
            cur_player_q <= 1'b0;
          end
        end
        SHOW: begin
          // Presses here are simply not acted on, including in the last cycle.
          if (timer == '0) begin
            round_q <= round_next;
            if (game_over) begin
              state       <= FINAL;
              times_q     <= 1'b1;
              is_final_q  <= 1'b1;
              is_finish_q <= 1'b1;
            end else begin
              die1_q  <= '0;
              die2_q  <= '0;
              state   <= WAIT1;
              times_q <= 1'b1;
            end
          end else begin
            timer <= timer - TMR_W'(1);
          end
        end
        FINAL: begin
          if (roll_p) begin
            state       <= IDLE;
            times_q     <= 1'b0;
            is_final_q  <= 1'b0;
            is_finish_q <= 1'b0;
            score1_q    <= '0;
            score2_q    <= '0;
            die1_q      <= '0;
            die2_q      <= '0;
            round_q     <= '0;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.times      = times_q;
  assign bus.is_final   = is_final_q;
  assign bus.is_finish  = is_finish_q;
  assign bus.score1     = score1_q;
  assign bus.score2     = score2_q;
  assign bus.die1       = die1_q;
  assign bus.die2       = die2_q;
  assign bus.cur_player = cur_player_q;
  assign bus.round_no   = round_q;

endmodule

// File: doc/dice_game_ctrl.md
# dice_game_ctrl

Round sequencer for the two-player dice game. It accepts roll requests and die values, alternates the players, and scores each round. It drives the LED display block through `times`, `is_final`, `is_finish`, `score1` and `score2`, and decides the winner, including sudden-death rounds on a tie. It sits between the button/debounce and dice-generator logic and the RGB display.

## Interface
Parameters:
- `ROUNDS`, 3: regulation rounds per game (1..14).
- `MAX_ROUNDS`, 15: hard cap on rounds including sudden death (ROUNDS..15).
- `SHOW_CYCLES`, 50_000_000: cycles the round result is held before the next round.

Ports:
- `clk`, in, 1: system clock, rising edge.
- `rst`, in, 1: synchronous, active-high reset (already decided).
- `roll`, in, 1: debounced, synchronised roll button level. The block edge-detects it internally.
- `dice_value`, in, 3: current die face from the dice generator. Only 1..6 is valid.
- `times`, out, 1: display enable. High = chase/standby animation, or the winner pattern when final.
- `is_final`, out, 1: game decided; display shows the winner.
- `is_finish`, out, 1: game over, level-held until a new game starts.
- `score1`, `score2`, out, 4 each: player scores.
- `die1`, `die2`, out, 3 each: last latched faces, 0 = none.
- `cur_player`, out, 1: 0 = player 1 to roll, 1 = player 2.
- `round_no`, out, 4: rounds completed.

## Operation
- `roll_p` = `roll & ~roll_d`, with `roll_d` registered. A held level produces exactly one pulse.
- States:
  - IDLE: `times` = 0. `roll_p` → WAIT1.
  - WAIT1: `times` = 1, `cur_player` = 0. `roll_p` with `dice_value` in 1..6 → latch `die1`, then → WAIT2. An invalid face (0 or 7) is ignored and the state is held.
  - WAIT2: `times` = 1, `cur_player` = 1. `roll_p` with a valid face → latch `die2`, score the round, load the show timer with SHOW_CYCLES-1, then → SHOW.
    - `die1` > `die2`: `score1` +1.
    - `die1` < `die2`: `score2` +1.
    - Equal: no change.
    - Scores saturate at 15.
  - SHOW: `times` = 0. `roll_p` is ignored. When the timer reaches 0, `round_no` +1. Let n = the new `round_no`:
    - n ≥ ROUNDS and scores differ → FINAL.
    - n = MAX_ROUNDS → FINAL. A tie here resolves to player 2, matching the display.
    - Otherwise: clear `die1`/`die2` → WAIT1.
  - FINAL: `times` = `is_final` = `is_finish` = 1. `roll_p` clears scores, dice and `round_no` → IDLE.
- Outputs are registered and decoded from the state register.

## Timing
- Reset values:
  - State IDLE.
  - All outputs 0.
  - `roll_d` = 1, so a button held through reset does not fire.
  - Timer 0.
- Reset mid-game aborts immediately on the next edge. No partial score survives.
- Latency: `roll` rises and is sampled at edge k. At edge k+1 `roll_d` is high, and the die latch, score update and state change are all visible after edge k.
  - Concretely: `roll_p` is combinational from the sampled `roll` and the old `roll_d`.
  - The registers update on the same edge that first samples `roll` = 1.
- SHOW lasts exactly SHOW_CYCLES cycles, from the first SHOW cycle to the last, before the next state.
- `is_final`, `times` and the scores change on the same edge, so the display never sees `is_final` with stale scores.
- `roll_p` in the last SHOW cycle is dropped, not queued.

## Structure
- Package `dice_game_pkg`:
  - State encoding: IDLE, WAIT1, WAIT2, SHOW, FINAL.
  - `SCORE_W` = 4 and `DIE_W` = 3.
  - Constants `DIE_MIN` = 1, `DIE_MAX` = 6, `SCORE_MAX` = 15.
- One sub-module, `rise_pulse`: the register plus AND edge detector with a reset value input. Everything else stays in the top module.

## Test plan
- Scenario 1 (regulation win), with SHOW_CYCLES = 4 for all scenarios:
  - Stimulus: start, then rolls (5,2), (3,1), (4,6).
  - Response: `score1` = 2, `score2` = 1, FINAL after round 3.
  - Response: `is_final` = `is_finish` = `times` = 1, with the scores stable on the same cycle.
- Scenario 2 (sudden death): rolls (2,5), (6,1), (3,3), (4,4), (1,2).
  - Response: tie 1–1 after round 3. Rounds 4 and 5 are played.
  - Response: FINAL with `score2` = 2 and `round_no` = 5.
- Scenario 3 (input filtering):
  - `roll` held high for 100 cycles → exactly one pulse.
  - `dice_value` = 0 or 7 on a pulse → no latch, state unchanged.
  - Pulses during SHOW → ignored.
- Scenario 4 (MAX_ROUNDS cap): ROUNDS = 1, MAX_ROUNDS = 3, all rolls equal.
  - Response: FINAL after round 3 with scores 0–0. `times` = 1, `is_final` = 1.
- Scenario 5 (reset mid-game): `rst` asserted in WAIT2 with `score1` = 1, `roll` held high.
  - Response: next cycle state IDLE and all outputs 0.
  - Response: no pulse until `roll` falls and rises again.
- Scenario 6 (new game): `roll_p` in FINAL → IDLE with scores and dice 0. The next `roll_p` → WAIT1.
